ysyx_23060208_rd_rr_arbiter: RTL and testbench
==============================================

Name: ysyx_23060208_rd_rr_arbiter

Overview:
- Round-robin read-channel arbiter sharing one AXI-lite read slave (unified SRAM) between master 0 (IFU fetch) and master 1 (LSU load).
- Holds the grant for the full AR→R transaction.
- Guards the data phase with a timeout that returns DECERR to the owner, then drains the late slave response.
- Write channels bypass this block.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
TIMEOUT, 255, max DATA-phase cycles waiting for s_rvalid (≥2)
ERRCNT_W, 8, width of timeout error counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
m0_araddr  in  ADDR_WIDTH  master 0 read address
m0_arvalid  in  1  master 0 AR valid
m0_arready  out  1  master 0 AR ready
m0_rdata  out  DATA_WIDTH  master 0 read data
m0_rresp  out  2  master 0 read response
m0_rvalid  out  1  master 0 R valid
m0_rready  in  1  master 0 R ready
m1_*  same seven signals/directions/widths as m0_*, for master 1
s_araddr  out  ADDR_WIDTH  slave address
s_arvalid  out  1  slave AR valid
s_arready  in  1  slave AR ready
s_rdata  in  DATA_WIDTH  slave data
s_rresp  in  2  slave response
s_rvalid  in  1  slave R valid
s_rready  out  1  slave R ready
err_cnt  out  ERRCNT_W  saturating count of timeouts

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `rst` is asynchronous and active-high.
  - Reset, including mid-transaction, immediately forces: state=IDLE, owner=0, prio=0 (m0 favoured), tcnt=0, err_cnt=0.
  - All handshake/data outputs are 0 during and after reset until the next grant.
- Output mapping:
  - Outputs are combinational from registered state/owner plus the selected inputs.
  - A non-owner master always sees arready=0, rvalid=0, rdata=0, rresp=0.
- States: IDLE, ADDR, DATA, ERR, DRAIN.
- IDLE:
  - All outputs 0.
  - Only m0_arvalid → owner=0. Only m1_arvalid → owner=1. Both → owner=prio.
  - With any arvalid, next state=ADDR. Arbitration adds exactly 1 cycle; there is no combinational pass-through in IDLE.
- ADDR:
  - s_araddr/s_arvalid = owner's araddr/arvalid; owner arready = s_arready.
  - On s_arvalid&s_arready → DATA, tcnt=0.
  - Masters must hold arvalid/araddr until accepted. A request from the non-owner waits.
- DATA:
  - Owner rdata/rresp/rvalid = s_rdata/s_rresp/s_rvalid; s_rready = owner rready.
  - On s_rvalid&s_rready → IDLE, prio=~owner (round-robin rotates only on successful completion).
  - Each cycle without s_rvalid, tcnt++.
  - When tcnt==TIMEOUT-1 and s_rvalid=0 → ERR, err_cnt++ (saturating at all-ones).
  - s_rvalid in the same cycle as the timeout threshold takes priority: normal path, no error.
- ERR:
  - Owner rvalid=1, rresp=2'b11, rdata=0; s_rready=0.
  - Held until owner rready → DRAIN, prio=~owner.
- DRAIN:
  - No master-facing outputs are active. s_rready=1.
  - On s_rvalid → IDLE; that data is discarded.
  - DRAIN waits indefinitely; new requests are held off until it exits.
- Width/other:
  - tcnt is an internal counter sized $clog2(TIMEOUT+1).
  - s_araddr=0 outside ADDR.
  - One transaction is outstanding at most.

Test Plan:
- Reset then m0_arvalid only, addr 0x8000_0000; slave arready at once, rvalid 2 cycles later with rdata 0x1234_5678 → m0 sees arready in cycle 2 after request, then rdata 0x1234_5678 rresp 0; prio becomes 1.
- m0 and m1 arvalid together for 4 back-to-back transactions → grant order m0,m1,m0,m1; no m1 output asserts during m0 ownership.
- m1 owns DATA, m0 raises arvalid mid-transaction → m0 waits; granted 1 cycle after m1 R handshake.
- TIMEOUT=4, slave never asserts rvalid → owner gets rvalid with rresp 2'b11 and rdata 0 after 4 DATA cycles; err_cnt=1. Slave rvalid 10 cycles later is absorbed with s_rready=1, the master sees nothing, and the block returns to IDLE.
- s_rvalid arrives on exactly the timeout-threshold cycle → normal completion, err_cnt unchanged.
- Async rst pulse mid-DATA (between clock edges) → all outputs 0 immediately; state IDLE, prio 0, err_cnt 0 after release.

Source files
------------

// File: rtl/ysyx_23060208_rd_rr_arbiter.sv
// rtl/ysyx_23060208_rd_rr_arbiter.sv - round-robin read arbiter with data-phase timeout
//
// Shares one AXI-lite read slave between master 0 (IFU) and master 1 (LSU).
// The grant is held from AR through R. If the data phase stalls for TIMEOUT
// cycles, the owner receives DECERR and the late slave beat is drained.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   m0_* / m1_*       master-side AR (araddr/arvalid/arready) and R (rdata/rresp/rvalid/rready)
//   s_*               slave-side AR and R channels
//   err_cnt           saturating count of data-phase timeouts
module ysyx_23060208_rd_rr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int ERRCNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [ERRCNT_W-1:0]   err_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        ERR   = 3'd3,
        DRAIN = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  prio_q, prio_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

    // Owner-selected master inputs
    logic [ADDR_WIDTH-1:0] sel_araddr;
    logic                  sel_arvalid;
    logic                  sel_rready;

    // Owner-facing outputs before routing to m0/m1
    logic                  own_arready;
    logic [DATA_WIDTH-1:0] own_rdata;
    logic [1:0]            own_rresp;
    logic                  own_rvalid;

    assign sel_araddr  = owner_q ? m1_araddr  : m0_araddr;
    assign sel_arvalid = owner_q ? m1_arvalid : m0_arvalid;
    assign sel_rready  = owner_q ? m1_rready  : m0_rready;
    assign err_cnt     = err_cnt_q;

    // Output mapping: purely a function of registered state/owner and the
    // selected inputs, so IDLE never passes a request straight through.
    always_comb begin
        own_arready = 1'b0;
        own_rdata   = '0;
        own_rresp   = 2'b00;
        own_rvalid  = 1'b0;
        s_araddr    = '0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        case (state_q)
            ADDR: begin
                s_araddr    = sel_araddr;
                s_arvalid   = sel_arvalid;
                own_arready = s_arready;
            end
            DATA: begin
                own_rdata  = s_rdata;
                own_rresp  = s_rresp;
                own_rvalid = s_rvalid;
                s_rready   = sel_rready;
            end
            ERR: begin
                own_rvalid = 1'b1;
                own_rresp  = 2'b11;
            end
            DRAIN: begin
                // Swallow the late beat; nothing reaches either master.
                s_rready = 1'b1;
            end
            default: ;
        endcase

        m0_arready = ~owner_q & own_arready;
        m0_rvalid  = ~owner_q & own_rvalid;
        m0_rdata   = owner_q ? '0 : own_rdata;
        m0_rresp   = owner_q ? 2'b00 : own_rresp;
        m1_arready = owner_q & own_arready;
        m1_rvalid  = owner_q & own_rvalid;
        m1_rdata   = owner_q ? own_rdata : '0;
        m1_rresp   = owner_q ? own_rresp : 2'b00;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        tcnt_d    = tcnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    owner_d = (m0_arvalid && m1_arvalid) ? prio_q : m1_arvalid;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (sel_arvalid && s_arready) begin
                    state_d = DATA;
                    tcnt_d  = '0;
                end
            end
            DATA: begin
                // A beat on the threshold cycle wins over the timeout.
                if (s_rvalid && sel_rready) begin
                    state_d = IDLE;
                    prio_d  = ~owner_q;
                end else if (!s_rvalid) begin
                    if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        state_d = ERR;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            ERR: begin
                if (sel_rready) begin
                    state_d = DRAIN;
                    prio_d  = ~owner_q;
                end
            end
            DRAIN: begin
                if (s_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            tcnt_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            tcnt_q    <= tcnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_rd_rr_arbiter.sv
// tb/tb_ysyx_23060208_rd_rr_arbiter.sv - scoreboard bench for the read arbiter
module tb_ysyx_23060208_rd_rr_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    ysyx_23060208_rd_rr_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO), .ERRCNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .err_cnt(err_cnt)
    );

    typedef struct {
        int          m;
        logic [31:0] d;
        logic [1:0]  r;
        int          cyc;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        obs_q[$];
    logic [31:0] m0_req_q[$];
    logic [31:0] m1_req_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int viol = 0;
    int s_ar_cyc = -1;
    int m0_ar_cyc = -1;
    int m1_ar_cyc = -1;

    int          slv_lat = 0;
    bit          slv_silent = 0;
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'h9234_5678;
    endfunction

    function automatic rec_t mk(input int m, input logic [31:0] d, input logic [1:0] r);
        rec_t x;
        x.m = m; x.d = d; x.r = r; x.cyc = 0;
        return x;
    endfunction

    function automatic bit master_quiet();
        return {m0_arready, m0_rvalid, m0_rdata, m0_rresp,
                m1_arready, m1_rvalid, m1_rdata, m1_rresp} == '0;
    endfunction

    task automatic update_masters(input bit m0_hs, input bit m1_hs);
        if (m0_hs && m0_req_q.size() > 0) void'(m0_req_q.pop_front());
        if (m1_hs && m1_req_q.size() > 0) void'(m1_req_q.pop_front());
        m0_arvalid = (m0_req_q.size() > 0);
        m0_araddr  = (m0_req_q.size() > 0) ? m0_req_q[0] : 32'h0;
        m1_arvalid = (m1_req_q.size() > 0);
        m1_araddr  = (m1_req_q.size() > 0) ? m1_req_q[0] : 32'h0;
    endtask

    // One clock: sample at negedge, then update slave/master stimulus after the edge.
    task automatic step();
        bit sar, sr, m0a, m1a, m0act, m1act;
        logic [31:0] sar_addr;
        rec_t o;
        @(negedge clk);
        sar = s_arvalid & s_arready;
        sar_addr = s_araddr;
        sr  = s_rvalid & s_rready;
        m0a = m0_arvalid & m0_arready;
        m1a = m1_arvalid & m1_arready;
        if (m0_rvalid && m0_rready) begin
            o.m = 0; o.d = m0_rdata; o.r = m0_rresp; o.cyc = cyc; obs_q.push_back(o);
        end
        if (m1_rvalid && m1_rready) begin
            o.m = 1; o.d = m1_rdata; o.r = m1_rresp; o.cyc = cyc; obs_q.push_back(o);
        end
        m0act = m0_arready | m0_rvalid | (|m0_rdata) | (|m0_rresp);
        m1act = m1_arready | m1_rvalid | (|m1_rdata) | (|m1_rresp);
        if (m0act && m1act) viol++;
        if (sar) s_ar_cyc = cyc;
        if (m0a) m0_ar_cyc = cyc;
        if (m1a) m1_ar_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (sr) begin
            s_rvalid = 1'b0; s_rdata = '0; pend = 0;
        end
        if (sar) begin
            pend = 1; cnt = slv_lat; pend_addr = sar_addr;
            if (cnt == 0 && !slv_silent) begin
                s_rvalid = 1'b1; s_rdata = slave_data(pend_addr);
            end
        end else if (pend && !slv_silent && !s_rvalid) begin
            cnt--;
            if (cnt <= 0) begin
                s_rvalid = 1'b1; s_rdata = slave_data(pend_addr);
            end
        end
        update_masters(m0a, m1a);
        #1;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int b;
        b = budget;
        while (obs_q.size() < n && b > 0) begin
            step();
            b--;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete(); obs_q.delete(); m0_req_q.delete(); m1_req_q.delete();
        m0_arvalid = 0; m0_araddr = 0; m0_rready = 1;
        m1_arvalid = 0; m1_araddr = 0; m1_rready = 1;
        s_arready = 1; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        pend = 0; slv_silent = 0; slv_lat = 0; viol = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (!master_quiet() || s_arvalid !== 1'b0 || s_araddr !== 32'h0 || s_rready !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got arv=%b addr=%h rrdy=%b want all zero", s_arvalid, s_araddr, s_rready);
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_err_cnt got=%0d want=0", err_cnt);
        end
    endtask

    task automatic test_single_m0();
        bit ok;
        rec_t e, o;
        slv_lat = 2;
        m0_req_q.push_back(32'h8000_0000);
        exp_q.push_back(mk(0, 32'h1234_5678, 2'b00));
        update_masters(0, 0);
        #1;
        checks++;
        if (m0_arready !== 1'b0 || s_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_passthru got arready=%b s_arvalid=%b want 0 0", m0_arready, s_arvalid);
        end
        step();
        checks++;
        if (m0_arready !== 1'b1 || s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000 || m1_arready !== 1'b0) begin
            failures++;
            $display("FAIL addr_phase got arready=%b s_arvalid=%b s_araddr=%h want 1 1 80000000", m0_arready, s_arvalid, s_araddr);
        end
        wait_obs(1, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_timeout got=%0d want=1 beats", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.m !== e.m || o.d !== e.d || o.r !== e.r) begin
                failures++;
                $display("FAIL single_data got m%0d %h/%0d want m%0d %h/%0d", o.m, o.d, o.r, e.m, e.d, e.r);
            end
        end
        // prio is now 1: simultaneous requests must grant m1 first
        slv_lat = 0;
        m0_req_q.push_back(32'h0000_0100);
        m1_req_q.push_back(32'h0000_0200);
        exp_q.push_back(mk(1, slave_data(32'h0000_0200), 2'b00));
        exp_q.push_back(mk(0, slave_data(32'h0000_0100), 2'b00));
        update_masters(0, 0);
        wait_obs(2, 40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL prio_timeout got=%0d want=2 beats", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                checks++;
                if (o.m !== e.m || o.d !== e.d || o.r !== e.r) begin
                    failures++;
                    $display("FAIL prio_order[%0d] got m%0d %h want m%0d %h", i, o.m, o.d, e.m, e.d);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        rec_t e, o;
        do_reset();
        slv_lat = 1;
        m0_req_q.push_back(32'h1000); m0_req_q.push_back(32'h3000);
        m1_req_q.push_back(32'h2000); m1_req_q.push_back(32'h4000);
        exp_q.push_back(mk(0, slave_data(32'h1000), 2'b00));
        exp_q.push_back(mk(1, slave_data(32'h2000), 2'b00));
        exp_q.push_back(mk(0, slave_data(32'h3000), 2'b00));
        exp_q.push_back(mk(1, slave_data(32'h4000), 2'b00));
        update_masters(0, 0);
        wait_obs(4, 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_timeout got=%0d want=4 beats", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                checks++;
                if (o.m !== e.m || o.d !== e.d || o.r !== e.r) begin
                    failures++;
                    $display("FAIL b2b_order[%0d] got m%0d %h/%0d want m%0d %h/%0d", i, o.m, o.d, o.r, e.m, e.d, e.r);
                end
            end
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL b2b_exclusive got=%0d overlap cycles want=0", viol);
        end
    endtask

    task automatic test_wait_nonowner();
        bit ok;
        int b;
        int r_cyc;
        rec_t e, o;
        slv_lat = 3;
        m0_ar_cyc = -1; m1_ar_cyc = -1;
        m1_req_q.push_back(32'h5000);
        exp_q.push_back(mk(1, slave_data(32'h5000), 2'b00));
        exp_q.push_back(mk(0, slave_data(32'h6000), 2'b00));
        update_masters(0, 0);
        b = 10;
        while (m1_ar_cyc < 0 && b > 0) begin step(); b--; end
        m0_req_q.push_back(32'h6000);
        update_masters(0, 0);
        wait_obs(2, 40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_timeout got=%0d want=2 beats", obs_q.size());
        end else begin
            r_cyc = obs_q[0].cyc;
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                checks++;
                if (o.m !== e.m || o.d !== e.d || o.r !== e.r) begin
                    failures++;
                    $display("FAIL wait_order[%0d] got m%0d %h want m%0d %h", i, o.m, o.d, e.m, e.d);
                end
            end
            checks++;
            if (m0_ar_cyc != r_cyc + 2) begin
                failures++;
                $display("FAIL wait_grant_cycle got=%0d want=%0d", m0_ar_cyc, r_cyc + 2);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int bad;
        rec_t e, o;
        s_ar_cyc = -1;
        slv_silent = 1;
        m0_req_q.push_back(32'h7000);
        exp_q.push_back(mk(0, 32'h0, 2'b11));
        update_masters(0, 0);
        wait_obs(1, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_no_err got=%0d want=1 beats", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.m !== e.m || o.d !== e.d || o.r !== e.r) begin
                failures++;
                $display("FAIL timeout_resp got m%0d %h/%0d want m%0d %h/%0d", o.m, o.d, o.r, e.m, e.d, e.r);
            end
            checks++;
            if (o.cyc != s_ar_cyc + 1 + TO) begin
                failures++;
                $display("FAIL timeout_cycle got=%0d want=%0d", o.cyc, s_ar_cyc + 1 + TO);
            end
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL timeout_err_cnt got=%0d want=1", err_cnt);
        end
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (!master_quiet() || s_rready !== 1'b1) bad++;
            step();
        end
        s_rvalid = 1'b1;
        s_rdata = 32'hDEAD_BEEF;
        #1;
        if (!master_quiet() || s_rready !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL drain_quiet got=%0d bad cycles want=0", bad);
        end
        step();
        checks++;
        if (obs_q.size() != 0 || s_rready !== 1'b0 || s_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL drain_exit got beats=%0d s_rready=%b want 0 0", obs_q.size(), s_rready);
        end
        slv_silent = 0;
    endtask

    task automatic test_threshold();
        bit ok;
        rec_t e, o;
        s_ar_cyc = -1;
        slv_lat = TO - 1;
        m0_req_q.push_back(32'h8000);
        exp_q.push_back(mk(0, slave_data(32'h8000), 2'b00));
        update_masters(0, 0);
        wait_obs(1, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL thresh_timeout got=%0d want=1 beats", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.m !== e.m || o.d !== e.d || o.r !== e.r || o.cyc != s_ar_cyc + TO) begin
                failures++;
                $display("FAIL thresh_resp got %h/%0d@%0d want %h/%0d@%0d", o.d, o.r, o.cyc, e.d, e.r, s_ar_cyc + TO);
            end
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL thresh_err_cnt got=%0d want=1", err_cnt);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int b;
        rec_t e, o;
        s_ar_cyc = -1;
        slv_lat = 3;
        m1_req_q.push_back(32'h9000);
        update_masters(0, 0);
        b = 10;
        while (s_ar_cyc < 0 && b > 0) begin step(); b--; end
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (!master_quiet() || s_arvalid !== 1'b0 || s_rready !== 1'b0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL async_rst got m1_rv=%b s_rrdy=%b err=%0d want all zero", m1_rvalid, s_rready, err_cnt);
        end
        do_reset();
        slv_lat = 0;
        m0_req_q.push_back(32'hA000);
        m1_req_q.push_back(32'hB000);
        exp_q.push_back(mk(0, slave_data(32'hA000), 2'b00));
        exp_q.push_back(mk(1, slave_data(32'hB000), 2'b00));
        update_masters(0, 0);
        wait_obs(2, 40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL post_rst_timeout got=%0d want=2 beats", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                checks++;
                if (o.m !== e.m || o.d !== e.d) begin
                    failures++;
                    $display("FAIL post_rst_order[%0d] got m%0d want m%0d", i, o.m, e.m);
                end
            end
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL post_rst_err_cnt got=%0d want=0", err_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_arvalid = 0; m0_araddr = 0; m0_rready = 1;
        m1_arvalid = 0; m1_araddr = 0; m1_rready = 1;
        s_arready = 1; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        test_reset();
        test_single_m0();
        test_back_to_back();
        test_wait_nonowner();
        test_timeout();
        test_threshold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=%0d cycles want completion", cyc);
        $fatal(1);
    end

endmodule
